wb_sram_responder: RTL and testbench

//   Wishbone classic slave in the user project that services management-core

---
 rtl/wb_sram_pkg.sv | 28 ++
 rtl/wb_sram_addr_decode.sv | 31 +++
 rtl/wb_sram_responder.sv | 173 +++++++++++++++++
 tb/tb_wb_sram_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg
//   Shared types and constants for the Wishbone-to-OpenRAM responder.
//   - wb_sram_state_e : access sequencer states
//   - BASE_HI_DEFAULT : default wbs_adr_i[31:24] value that selects this slave
//   - MISS_RDATA      : read data returned when an access misses the window
//   - lat_load()      : latency-counter preload for a given macro read latency
package wb_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_ACK     = 3'd4
  } wb_sram_state_e;

  localparam logic [7:0]  BASE_HI_DEFAULT = 8'h30;
  localparam logic [31:0] MISS_RDATA      = 32'h0000_0000;

  // RD_WAIT always spends one cycle, so the counter only has to cover the
  // remaining latency. Out-of-range latencies are clamped to 1..3.
  function automatic logic [1:0] lat_load(input int unsigned lat);
    if (lat <= 1)      return 2'd0;
    else if (lat >= 3) return 2'd2;
    else               return 2'd1;
  endfunction

endpackage

// File: rtl/wb_sram_addr_decode.sv
// wb_sram_addr_decode
//   Combinational split of a Wishbone byte address into window hit, macro
//   index and macro word address. Byte offset bits [1:0] are ignored.
//   Ports:
//     adr        in  32          Wishbone byte address
//     hit        out 1           adr[31:24] matches BASE_HI
//     word_addr  out ADDR_WIDTH  macro word address, adr[ADDR_WIDTH+1:2]
//     macro_sel  out SEL_BITS    macro index, field just above the word address
module wb_sram_addr_decode
  import wb_sram_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter int         SEL_BITS   = 4,
  parameter logic [7:0] BASE_HI    = BASE_HI_DEFAULT
) (
  input  logic [31:0]           adr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic [SEL_BITS-1:0]   macro_sel
);

  assign hit       = (adr[31:24] == BASE_HI);
  assign word_addr = adr[ADDR_WIDTH+1:2];
  assign macro_sel = adr[ADDR_WIDTH+2 +: SEL_BITS];

  // Byte offset and any bits between the select field and the base byte
  // carry no meaning here.
  logic unused_adr;
  assign unused_adr = ^adr;

endmodule

// File: rtl/wb_sram_responder.sv
// wb_sram_responder
//   Wishbone classic slave that turns management-core accesses into
//   single-port OpenRAM macro strobes. One access is in flight at a time;
//   every sampled request receives exactly one ack (misses ack with err_o).
//   Ports:
//     wb_clk_i      in   1           clock, rising edge
//     resetn        in   1           async assert, internally synchronised release
//     wbs_cyc_i     in   1           bus cycle valid
//     wbs_stb_i     in   1           strobe; request = cyc & stb
//     wbs_we_i      in   1           1 = write
//     wbs_sel_i     in   4           byte lanes (become the macro write mask)
//     wbs_adr_i     in   32          byte address
//     wbs_dat_i     in   DATA_WIDTH  write data
//     wbs_ack_o     out  1           one-cycle acknowledge
//     wbs_dat_o     out  DATA_WIDTH  read data, held until next read or miss
//     sram_sel_o    out  SEL_BITS    macro index
//     sram_csb_o    out  1           macro chip select, active low
//     sram_web_o    out  1           macro write enable, active low
//     sram_wmask_o  out  4           macro byte write mask
//     sram_addr_o   out  ADDR_WIDTH  macro word address
//     sram_din_o    out  DATA_WIDTH  macro write data
//     sram_dout_i   in   DATA_WIDTH  read data from the selected macro
//     err_o         out  1           pulses with ack on an address miss
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for cyc&stb; latches address/data, fires the strobe
//   ST_WR      | write strobe done; release csb/web
//   ST_RD_WAIT | read strobe done; wait out the macro read latency
//   ST_RD_CAP  | capture sram_dout_i into wbs_dat_o
//   ST_ACK     | ack (and err on a miss) high for this one cycle
module wb_sram_responder
  import wb_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          SEL_BITS   = 4,
  parameter logic [7:0]  BASE_HI    = BASE_HI_DEFAULT,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  resetn,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic [SEL_BITS-1:0]   sram_sel_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [3:0]            sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i,
  output logic                  err_o
);

  localparam logic [1:0] LAT_LOAD = lat_load(RD_LATENCY);

  // Reset asserts asynchronously (strobes drop at once) but releases on a
  // clock edge so the FSM never leaves reset on a partial cycle.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic                  dec_hit;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [SEL_BITS-1:0]   dec_sel;

  wb_sram_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_BITS   (SEL_BITS),
    .BASE_HI    (BASE_HI)
  ) u_decode (
    .adr       (wbs_adr_i),
    .hit       (dec_hit),
    .word_addr (dec_addr),
    .macro_sel (dec_sel)
  );

  logic req;
  assign req = wbs_cyc_i & wbs_stb_i;

  wb_sram_state_e state;
  logic [1:0]     lat_cnt;

  // ack/err default low every cycle and are only raised on the edge that
  // enters ST_ACK, so they are high exactly while the FSM sits in ST_ACK.
  // IDLE therefore never sees the request that was just acknowledged.
  always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= ST_IDLE;
      lat_cnt      <= 2'd0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      err_o        <= 1'b0;
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_wmask_o <= 4'h0;
      sram_addr_o  <= '0;
      sram_din_o   <= '0;
      sram_sel_o   <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            sram_addr_o  <= dec_addr;
            sram_sel_o   <= dec_sel;
            sram_din_o   <= wbs_dat_i;
            sram_wmask_o <= wbs_sel_i;
            if (!dec_hit) begin
              wbs_dat_o <= MISS_RDATA[DATA_WIDTH-1:0];
              wbs_ack_o <= 1'b1;
              err_o     <= 1'b1;
              state     <= ST_ACK;
            end else if (wbs_we_i) begin
              sram_csb_o <= 1'b0;
              sram_web_o <= 1'b0;
              state      <= ST_WR;
            end else begin
              sram_csb_o <= 1'b0;
              sram_web_o <= 1'b1;
              lat_cnt    <= LAT_LOAD;
              state      <= ST_RD_WAIT;
            end
          end
        end

        ST_WR: begin
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          wbs_ack_o  <= 1'b1;
          state      <= ST_ACK;
        end

        ST_RD_WAIT: begin
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          if (lat_cnt == 2'd0) state   <= ST_RD_CAP;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end

        ST_RD_CAP: begin
          wbs_dat_o <= sram_dout_i;
          wbs_ack_o <= 1'b1;
          state     <= ST_ACK;
        end

        ST_ACK: begin
          state <= ST_IDLE;
        end

        default: begin
          sram_csb_o <= 1'b1;
          sram_web_o <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_responder.sv
module tb_wb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Index 0: RD_LATENCY=1 instance, index 1: RD_LATENCY=3 instance.
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] dat_w [2];
  logic        ack   [2];
  logic [31:0] dat_r [2];
  logic [3:0]  msel  [2];
  logic        csb   [2];
  logic        web   [2];
  logic [3:0]  wmask [2];
  logic [7:0]  maddr [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        err   [2];

  wb_sram_responder #(.RD_LATENCY(1)) u_dut_l1 (
    .wb_clk_i(clk), .resetn(resetn),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
    .wbs_adr_i(adr[0]), .wbs_dat_i(dat_w[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_r[0]),
    .sram_sel_o(msel[0]), .sram_csb_o(csb[0]), .sram_web_o(web[0]), .sram_wmask_o(wmask[0]),
    .sram_addr_o(maddr[0]), .sram_din_o(din[0]), .sram_dout_i(dout[0]), .err_o(err[0])
  );

  wb_sram_responder #(.RD_LATENCY(3)) u_dut_l3 (
    .wb_clk_i(clk), .resetn(resetn),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
    .wbs_adr_i(adr[1]), .wbs_dat_i(dat_w[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_r[1]),
    .sram_sel_o(msel[1]), .sram_csb_o(csb[1]), .sram_web_o(web[1]), .sram_wmask_o(wmask[1]),
    .sram_addr_o(maddr[1]), .sram_din_o(din[1]), .sram_dout_i(dout[1]), .err_o(err[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Behavioural single-port macro bank: samples csb on the rising edge,
  // byte-masked write, read data valid RD_LATENCY edges after the sample.
  logic [31:0] mem     [2][16][256];
  logic [31:0] rd_word [2];
  int          rd_cnt  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_cnt[k] != 0) begin
        if (rd_cnt[k] == 1) dout[k] <= rd_word[k];
        rd_cnt[k] <= rd_cnt[k] - 1;
      end
      if (!csb[k]) begin
        if (!web[k]) begin
          for (int b = 0; b < 4; b++)
            if (wmask[k][b]) mem[k][msel[k]][maddr[k]][8*b +: 8] <= din[k][8*b +: 8];
        end else if (lat_of(k) == 1) begin
          dout[k] <= mem[k][msel[k]][maddr[k]];
        end else begin
          dout[k]    <= 32'hDEAD_BEEF;
          rd_word[k] <= mem[k][msel[k]][maddr[k]];
          rd_cnt[k]  <= lat_of(k) - 1;
        end
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string what, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (RD_LATENCY=%0d): got %0h expected %0h", what, lat_of(k), act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        err;
    logic [3:0]  msel;
    logic [7:0]  maddr;
    logic [31:0] rdat;   // wbs_dat_o expected at ack (held value on writes)
  } vec_t;

  vec_t vecs [15];

  // Drives one access on both instances and checks strobe, decode, ack
  // timing/count, read data and err. Call at a negedge.
  task automatic run_access(input vec_t v, input int id);
    int          ack_cnt [2];
    int          ack_n   [2];
    int          csb_cnt [2];
    int          csb_n   [2];
    int          stray   [2];
    logic        s_web   [2];
    logic [7:0]  s_addr  [2];
    logic [3:0]  s_sel   [2];
    logic [3:0]  s_mask  [2];
    logic [31:0] s_din   [2];
    logic [31:0] a_dat   [2];
    logic        a_err   [2];
    int          exp_lat;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = v.we; sel[k] = v.sel;
      adr[k] = v.adr; dat_w[k] = v.wdat;
      ack_cnt[k] = 0; ack_n[k] = 0; csb_cnt[k] = 0; csb_n[k] = 0; stray[k] = 0;
      s_web[k] = 1'b1; s_addr[k] = '0; s_sel[k] = '0; s_mask[k] = '0; s_din[k] = '0;
      a_dat[k] = 32'hXXXX_XXXX; a_err[k] = 1'b0;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!csb[k]) begin
          csb_cnt[k]++;
          if (csb_cnt[k] == 1) begin
            csb_n[k] = n; s_web[k] = web[k]; s_addr[k] = maddr[k];
            s_sel[k] = msel[k]; s_mask[k] = wmask[k]; s_din[k] = din[k];
          end
        end
        if (ack[k]) begin
          ack_cnt[k]++;
          if (ack_cnt[k] == 1) begin
            ack_n[k] = n; a_dat[k] = dat_r[k]; a_err[k] = err[k];
          end
          cyc[k] = 1'b0; stb[k] = 1'b0;
        end else if (err[k]) begin
          stray[k]++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      exp_lat = v.err ? 1 : (v.we ? 2 : lat_of(k) + 2);
      chk($sformatf("v%0d ack_count", id), k, ack_cnt[k], 1);
      chk($sformatf("v%0d ack_latency", id), k, ack_n[k], exp_lat);
      chk($sformatf("v%0d dat_o", id), k, a_dat[k], v.rdat);
      chk($sformatf("v%0d err_with_ack", id), k, {31'd0, a_err[k]}, {31'd0, v.err});
      chk($sformatf("v%0d err_without_ack", id), k, stray[k], 0);
      chk($sformatf("v%0d csb_low_cycles", id), k, csb_cnt[k], v.err ? 0 : 1);
      if (!v.err) begin
        chk($sformatf("v%0d csb_cycle", id), k, csb_n[k], 1);
        chk($sformatf("v%0d web", id), k, {31'd0, s_web[k]}, {31'd0, ~v.we});
        chk($sformatf("v%0d sram_addr", id), k, {24'd0, s_addr[k]}, {24'd0, v.maddr});
        chk($sformatf("v%0d sram_sel", id), k, {28'd0, s_sel[k]}, {28'd0, v.msel});
        if (v.we) begin
          chk($sformatf("v%0d wmask", id), k, {28'd0, s_mask[k]}, {28'd0, v.sel});
          chk($sformatf("v%0d sram_din", id), k, s_din[k], v.wdat);
        end
      end
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'h0101_0101 * 32'(i);
  endfunction

  task automatic load_txn(input int k, input int i);
    we[k]    = (i < 8);
    adr[k]   = 32'h3000_0100 + 32'(4 * (i % 8));
    dat_w[k] = (i < 8) ? pat(i) : 32'h0;
    sel[k]   = 4'hF;
  endtask

  // 8 writes then 8 reads with stb held; next request presented during ack.
  task automatic back_to_back();
    int idx    [2];
    int done_n [2];
    int stray  [2];
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; done_n[k] = 0; stray[k] = 0;
      load_txn(k, 0);
      cyc[k] = 1'b1; stb[k] = 1'b1;
    end
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ack[k]) begin
          if (idx[k] >= 16) begin
            stray[k]++;
          end else begin
            if (idx[k] >= 8)
              chk($sformatf("b2b read %0d", idx[k] - 8), k, dat_r[k], pat(idx[k] - 8));
            idx[k]++;
            if (idx[k] < 16) load_txn(k, idx[k]);
            else begin
              cyc[k] = 1'b0; stb[k] = 1'b0; done_n[k] = n;
            end
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("b2b ack_total", k, idx[k], 16);
      chk("b2b last_ack_cycle", k, done_n[k], 23 + 8 * (lat_of(k) + 3));
      chk("b2b extra_acks", k, stray[k], 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, " ack"}, k, {31'd0, ack[k]}, 32'd0);
      chk({tag, " dat_o"}, k, dat_r[k], 32'd0);
      chk({tag, " csb"}, k, {31'd0, csb[k]}, 32'd1);
      chk({tag, " web"}, k, {31'd0, web[k]}, 32'd1);
      chk({tag, " wmask"}, k, {28'd0, wmask[k]}, 32'd0);
      chk({tag, " addr"}, k, {24'd0, maddr[k]}, 32'd0);
      chk({tag, " din"}, k, din[k], 32'd0);
      chk({tag, " sel"}, k, {28'd0, msel[k]}, 32'd0);
      chk({tag, " err"}, k, {31'd0, err[k]}, 32'd0);
    end
  endtask

  task automatic issue_read(input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; sel[k] = 4'hF; adr[k] = a; dat_w[k] = '0;
    end
  endtask

  task automatic drop_req();
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0;
    end
  endtask

  initial begin
    int acks_after [2];
    int csb_after  [2];
    //            we    adr            sel    wdat           err   msel  maddr  rdat
    vecs[0]  = '{1'b1, 32'h3000_0010, 4'hF, 32'hA5A5_1234, 1'b0, 4'd0, 8'h04, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'hA5A5_1234};
    vecs[2]  = '{1'b1, 32'h3000_0010, 4'h2, 32'hFFFF_FFFF, 1'b0, 4'd0, 8'h04, 32'hA5A5_1234};
    vecs[3]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'hA5A5_FF34};
    vecs[4]  = '{1'b1, 32'h3000_0410, 4'hF, 32'hCAFE_F00D, 1'b0, 4'd1, 8'h04, 32'hA5A5_FF34};
    vecs[5]  = '{1'b0, 32'h3000_0410, 4'hF, 32'h0000_0000, 1'b0, 4'd1, 8'h04, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'hA5A5_FF34};
    vecs[7]  = '{1'b0, 32'h2000_0000, 4'hF, 32'h0000_0000, 1'b1, 4'd0, 8'h00, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h3000_0010, 4'h0, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'hA5A5_FF34};
    vecs[10] = '{1'b1, 32'h3000_07FC, 4'h9, 32'h1234_5678, 1'b0, 4'd1, 8'hFF, 32'hA5A5_FF34};
    vecs[11] = '{1'b0, 32'h3000_07FF, 4'hF, 32'h0000_0000, 1'b0, 4'd1, 8'hFF, 32'h1200_0078};
    vecs[12] = '{1'b0, 32'h3100_0010, 4'hF, 32'h0000_0000, 1'b1, 4'd0, 8'h00, 32'h0000_0000};
    vecs[13] = '{1'b1, 32'h0000_0010, 4'hF, 32'h5555_5555, 1'b1, 4'd0, 8'h00, 32'h0000_0000};
    vecs[14] = '{1'b0, 32'h3000_4010, 4'hF, 32'h0000_0000, 1'b0, 4'd0, 8'h04, 32'hA5A5_FF34};

    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 16; s++)
        for (int a = 0; a < 256; a++) mem[k][s][a] = 32'h0;
      dout[k] = 32'h0; rd_word[k] = 32'h0; rd_cnt[k] = 0;
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; adr[k] = 32'h0; dat_w[k] = 32'h0;
    end

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_release");

    for (int i = 0; i < 15; i++) run_access(vecs[i], i);

    back_to_back();

    // Reset while the read strobe is on the macro pins.
    repeat (2) @(negedge clk);
    issue_read(32'h3000_0010);
    @(negedge clk);
    chk("pre_reset csb_low", 1, {31'd0, csb[1]}, 32'd0);
    drop_req();
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_at_strobe csb", k, {31'd0, csb[k]}, 32'd1);
      chk("reset_at_strobe web", k, {31'd0, web[k]}, 32'd1);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while the RD_LATENCY=3 instance is in RD_WAIT.
    issue_read(32'h3000_0010);
    @(negedge clk);
    drop_req();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_in_rd_wait csb", k, {31'd0, csb[k]}, 32'd1);
      chk("reset_in_rd_wait web", k, {31'd0, web[k]}, 32'd1);
      chk("reset_in_rd_wait ack", k, {31'd0, ack[k]}, 32'd0);
      acks_after[k] = 0; csb_after[k] = 0;
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ack[k]) acks_after[k]++;
        if (!csb[k]) csb_after[k]++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("post_reset ack_count", k, acks_after[k], 0);
      chk("post_reset csb_low_cycles", k, csb_after[k], 0);
    end

    // Normal service resumes; macro contents survive the controller reset.
    run_access(vecs[6], 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
